// File: rtl/poco_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the poco data bus.
// TXDATA pushes into a small FIFO; STATUS reports count/ovf/busy/empty/full.
module poco_uart_tx #(
   parameter int                DATA_W     = 16,
   parameter logic [DATA_W-1:0] BASE_ADDR  = 16'hFFF0,
   parameter int                FIFO_DEPTH = 4,
   parameter int                CLK_DIV    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] daddr,
   input  logic [DATA_W-1:0] ddataout,
   input  logic              we,
   output logic [DATA_W-1:0] rdata,
   output logic              sel,
   output logic              txd,
   output logic              busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DATA_W-1:0] STAT_ADDR = BASE_ADDR + DATA_W'(1);
   localparam logic [CW-1:0]     DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [DW-1:0]     DIV_LAST  = DW'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          ovf;
   logic [7:0]    shift;
   logic [DW-1:0] div;
   logic [2:0]    bit_cnt;
   logic          txd_r;

   logic hit_data, hit_stat, push_req, full, empty, push, pop, div_end;
   logic [DATA_W-1:0] stat;
   logic unused_hi;

   assign hit_data = (daddr == BASE_ADDR);
   assign hit_stat = (daddr == STAT_ADDR);
   assign push_req = we && hit_data;
   assign full     = (count == DEPTH_C);
   assign empty    = (count == '0);
   // Full is judged before any same-cycle pop, so a write at full is always dropped.
   assign push     = push_req && !full;
   assign div_end  = (div == DIV_LAST);
   assign pop      = !empty && ((state == IDLE) || (state == STOP && div_end));
   assign unused_hi = ^ddataout[DATA_W-1:8];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (push_req && full)      ovf <= 1'b1;
         else if (we && hit_stat)   ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= ddataout[7:0];
   end

   always_ff @(posedge clk) begin
      if (pop)                         shift <= mem[rd_ptr];
      else if (state == DATA && div_end) shift <= shift >> 1;
   end

   // txd is registered and loaded with the level of the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         txd_r   <= 1'b1;
         div     <= '0;
         bit_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  state <= START;
                  txd_r <= 1'b0;
               end
            end
            START: begin
               if (div_end) begin
                  div   <= '0;
                  state <= DATA;
                  txd_r <= shift[0];
               end else begin
                  div <= div + 1'b1;
               end
            end
            DATA: begin
               if (div_end) begin
                  div <= '0;
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
                     state   <= STOP;
                     txd_r   <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     txd_r   <= shift[1];
                  end
               end else begin
                  div <= div + 1'b1;
               end
            end
            STOP: begin
               if (div_end) begin
                  div <= '0;
                  if (!empty) begin
                     state <= START;
                     txd_r <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  div <= div + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      stat = '0;
      if (rst) begin
         stat[1] = 1'b1;
      end else begin
         stat[8:4] = 5'(count);
         stat[3]   = ovf;
         stat[2]   = busy;
         stat[1]   = empty;
         stat[0]   = full;
      end
   end

   assign busy  = (state != IDLE) || !empty;
   assign txd   = txd_r;
   assign sel   = hit_data || hit_stat;
   assign rdata = hit_stat ? stat : '0;

endmodule

// File: tb/tb_poco_uart_tx.sv
// Directed bench for poco_uart_tx with CLK_DIV=4, FIFO_DEPTH=4.
module tb_poco_uart_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] daddr;
   logic [15:0] ddataout;
   logic        we;
   logic [15:0] rdata;
   logic        sel;
   logic        txd;
   logic        busy;

   int checks = 0;
   int errors = 0;

   poco_uart_tx #(
      .DATA_W    (16),
      .BASE_ADDR (16'hFFF0),
      .FIFO_DEPTH(4),
      .CLK_DIV   (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .daddr   (daddr),
      .ddataout(ddataout),
      .we      (we),
      .rdata   (rdata),
      .sel     (sel),
      .txd     (txd),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      daddr    = a;
      ddataout = d;
      we       = 1'b1;
      tick();
      we       = 1'b0;
      daddr    = 16'h0000;
   endtask

   task automatic rd(input logic [15:0] a, output logic [15:0] d);
      daddr = a;
      #1;
      d = rdata;
   endtask

   // Enter at cycle 2 of position 'from' (-1 = start bit, 0..7 data, 8 = stop);
   // leave at cycle 2 of the next frame's start (or the matching idle cycle).
   task automatic frame(input logic [7:0] b, input int from, input bit more, input string tag);
      logic e;
      for (int p = from; p <= 8; p++) begin
         e = (p < 0) ? 1'b0 : (p == 8) ? 1'b1 : b[p];
         check($sformatf("%s_pos%0d", tag, p), txd, e);
         if (p < 8) repeat (4) tick();
      end
      repeat (2) tick();
      if (more) begin
         check({tag, "_nogap"}, txd, 1'b0);
      end else begin
         check({tag, "_idle_txd"}, txd, 1'b1);
         check({tag, "_idle_busy"}, busy, 1'b0);
      end
      repeat (2) tick();
   endtask

   initial begin
      logic [15:0] d;
      logic [39:0] obs;
      logic [7:0]  b;
      bit          stuck;

      rst = 1'b1; we = 1'b0; daddr = 16'h0000; ddataout = 16'h0000;
      repeat (3) tick();
      check("rst_txd", txd, 1'b1);
      check("rst_busy", busy, 1'b0);
      rd(16'hFFF1, d);
      check("rst_status", d, 16'h0002);
      check("rst_sel", sel, 1'b1);
      rst = 1'b0;
      tick();

      // Status and decode
      rd(16'hFFF1, d);  check("idle_status", d, 16'h0002);
      rd(16'hFFF0, d);  check("txdata_read", d, 16'h0000);
      check("txdata_sel", sel, 1'b1);
      rd(16'h1234, d);  check("other_rdata", d, 16'h0000);
      check("other_sel", sel, 1'b0);
      wr(16'hFFF2, 16'h00AA);
      rd(16'hFFF1, d);  check("fff2_nopush", d, 16'h0002);
      repeat (5) tick();
      check("fff2_txd", txd, 1'b1);

      // Single byte: exact 40-cycle waveform
      wr(16'hFFF0, 16'h1255);
      rd(16'hFFF1, d);  check("single_status", d, 16'h0014);
      check("single_pre_txd", txd, 1'b1);
      tick();
      for (int k = 0; k < 40; k++) begin
         obs[k] = txd;
         if (k < 39) tick();
      end
      check("single_wave", obs, 40'hF0F0F0F0F0);
      tick();
      check("single_end_txd", txd, 1'b1);
      check("single_end_busy", busy, 1'b0);
      rd(16'hFFF1, d);  check("single_end_status", d, 16'h0002);
      repeat (3) tick();

      // Burst of 4, back-to-back frames
      for (int i = 1; i <= 4; i++) wr(16'hFFF0, 16'(i));
      rd(16'hFFF1, d);  check("burst_status", d, 16'h0034);
      frame(8'h01, -1, 1'b1, "burst1");
      frame(8'h02, -1, 1'b1, "burst2");
      frame(8'h03, -1, 1'b1, "burst3");
      frame(8'h04, -1, 1'b0, "burst4");
      repeat (3) tick();

      // Overflow: sixth consecutive write dropped
      for (int i = 1; i <= 6; i++) wr(16'hFFF0, 16'h0010 + 16'(i));
      rd(16'hFFF1, d);  check("ovf_status", d, 16'h004D);
      wr(16'hFFF1, 16'h0000);
      rd(16'hFFF1, d);  check("ovf_cleared", d, 16'h0045);
      tick();
      frame(8'h11, 0, 1'b1, "ovf1");
      frame(8'h12, -1, 1'b1, "ovf2");
      frame(8'h13, -1, 1'b1, "ovf3");
      frame(8'h14, -1, 1'b1, "ovf4");
      frame(8'h15, -1, 1'b0, "ovf5");
      stuck = 1'b1;
      for (int k = 0; k < 60; k++) begin
         if (txd !== 1'b1) stuck = 1'b0;
         tick();
      end
      check("ovf_dropped_never_sent", stuck, 1'b1);

      // Reset mid-frame during bit 3 (0x33 bit 3 = 0)
      wr(16'hFFF0, 16'h0033);
      wr(16'hFFF0, 16'h005A);
      wr(16'hFFF0, 16'h007E);
      repeat (17) tick();
      check("pre_rst_bit3", txd, 1'b0);
      rst = 1'b1;
      rd(16'hFFF1, d);  check("in_rst_status", d, 16'h0002);
      tick();
      check("midrst_txd", txd, 1'b1);
      check("midrst_busy", busy, 1'b0);
      rst = 1'b0;
      tick();
      rd(16'hFFF1, d);  check("postrst_status", d, 16'h0002);
      stuck = 1'b1;
      for (int k = 0; k < 100; k++) begin
         if (txd !== 1'b1 || busy !== 1'b0) stuck = 1'b0;
         tick();
      end
      check("postrst_quiet", stuck, 1'b1);

      // Pointer wrap: 10 bytes, one per frame
      for (int i = 0; i < 10; i++) begin
         b = 8'h81 + 8'(i * 29);
         wr(16'hFFF0, {8'hA5, b});
         tick();
         check($sformatf("wrap%0d_fall", i), txd, 1'b0);
         repeat (2) tick();
         frame(b, -1, 1'b0, $sformatf("wrap%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
